// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch queue.
//   fetch_state_e : fetch FSM state encoding (IDLE / WAIT / DISCARD)
//   fetch_entry_t : one buffered fetch result, {pc, instr}
//   INSTR_BYTES   : fetch stride in bytes
//   align_pc()    : forces an address onto an instruction-word boundary
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Masking (rather than slicing) keeps every input bit in use.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~(32'(INSTR_BYTES) - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO of fetch_entry_t with single-cycle flush.
// Head entry is presented combinationally from storage.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   flush_i        : empty the FIFO (pointers and count to zero), wins over
//                    push/pop in the same cycle
//   push_i         : write push_data_i at the tail (caller ensures not full)
//   push_data_i    : entry to write
//   pop_i          : advance the head (ignored when empty)
//   head_o         : entry at the head
//   count_o        : occupancy 0..DEPTH
//   empty_o/full_o : occupancy flags
// ---------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_ok;

  assign pop_ok = pop_i && !empty_o;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_i, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the head is qualified by empty_o downstream.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i && !rst_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
// Fetch front end: issues word fetches to a variable-latency instruction
// memory (at most one outstanding), buffers {pc, instr} in a FIFO and hands
// them to decode with valid/ready. A taken-branch redirect flushes the queue
// and drops any response still in flight.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   imem_req_o/addr_o   : one-cycle fetch request and its word address
//   imem_rvalid_i/rdata_i : response strobe and instruction word
//   redirect_i/pc_i     : taken branch and its target
//   if_valid_o          : head entry valid
//   if_instr_o/if_pc_o  : head entry (zero when empty)
//   id_ready_i          : decode consumes the head this cycle
//
// state   | meaning
// --------+------------------------------------------------
// IDLE    | no request outstanding; may issue
// WAIT    | one request outstanding; may re-issue on rvalid
// DISCARD | outstanding response belongs to a flushed path
// ---------------------------------------------------------------------------
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  input  logic        id_ready_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state_q;
  fetch_state_e     state_d;
  logic [31:0]      fetch_pc_q;
  logic [31:0]      inflight_pc_q;

  logic             issue;
  logic             push;
  logic             pop;
  logic             room;
  logic [CNT_W:0]   occ_after;

  fetch_entry_t     push_entry;
  fetch_entry_t     head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;

  // Redirect overrides both the pop and the push of this cycle.
  assign pop  = !fifo_empty && id_ready_i && !redirect_i;
  assign push = (state_q == WAIT) && imem_rvalid_i && !redirect_i && !fifo_full;

  // A new request needs a free slot once this cycle's push/pop settle, so a
  // response already on its way is counted before issuing another.
  assign occ_after = {1'b0, fifo_count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
  assign room      = occ_after < (CNT_W+1)'(DEPTH);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        // rvalid here is a protocol violation and is ignored.
        if (!redirect_i && room) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_i) begin
          state_d = imem_rvalid_i ? IDLE : DISCARD;
        end else if (imem_rvalid_i) begin
          if (room) begin
            issue   = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (imem_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_i) begin
        fetch_pc_q <= align_pc(redirect_pc_i);
      end else if (issue) begin
        inflight_pc_q <= fetch_pc_q;
        fetch_pc_q    <= fetch_pc_q + 32'(INSTR_BYTES);
      end
    end
  end

  assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata_i};

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign imem_req_o  = issue && !rst_i;
  assign imem_addr_o = fetch_pc_q;

  assign if_valid_o = !fifo_empty;
  assign if_pc_o    = fifo_empty ? 32'h0 : head.pc;
  assign if_instr_o = fifo_empty ? 32'h0 : head.instr;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue. A behavioural memory answers each
// request after `lat` cycles with rdata equal to the request address.
module tb_instr_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic        id_ready_i;

  always #5 clk_i = ~clk_i;

  instr_fetch_queue #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .if_valid_o    (if_valid_o),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .id_ready_i    (id_ready_i)
  );

  int errors = 0;
  int checks = 0;

  int          lat      = 1;
  bit          mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  logic        s_req;
  logic [31:0] s_addr;
  logic        s_vld;
  logic [31:0] s_pc;
  logic [31:0] s_instr;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a negedge: drive the memory response, sample outputs,
  // advance through the posedge, update the memory model.
  task automatic tick();
    imem_rvalid_i = mem_busy && (mem_cnt == 0);
    imem_rdata_i  = mem_addr;
    #1;
    s_req   = imem_req_o;
    s_addr  = imem_addr_o;
    s_vld   = if_valid_o;
    s_pc    = if_pc_o;
    s_instr = if_instr_o;
    @(posedge clk_i);
    if (imem_rvalid_i) mem_busy = 1'b0;
    if (s_req) begin
      mem_busy = 1'b1;
      mem_cnt  = lat - 1;
      mem_addr = s_addr;
    end else if (mem_busy && mem_cnt > 0) begin
      mem_cnt--;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    redirect_i = 1'b0;
    id_ready_i = 1'b0;
    repeat (4) tick();
    check32("rst_req",   32'(s_req), 32'd0);
    check32("rst_valid", 32'(s_vld), 32'd0);
    check32("rst_pc",    s_pc,       32'h0);
    check32("rst_instr", s_instr,    32'h0);
    rst_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
    bit          found = 1'b0;
    logic [31:0] pc    = '0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (s_vld) begin
        found = 1'b1;
        pc    = s_pc;
      end
    end
    check32({tag, "_seen"}, 32'(found), 32'd1);
    check32({tag, "_pc"},   pc,         exp_pc);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nreq;
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    id_ready_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    @(negedge clk_i);

    // 1-cycle memory streaming: one instruction per cycle.
    lat = 1;
    do_reset();
    id_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check32("stream_req",  32'(s_req), 32'd1);
      check32("stream_addr", s_addr,     32'(4 * k));
      if (k >= 2) begin
        check32("stream_valid", 32'(s_vld), 32'd1);
        check32("stream_pc",    s_pc,       32'(4 * (k - 2)));
        check32("stream_instr", s_instr,    32'(4 * (k - 2)));
      end
    end

    // Back-pressure: four requests fill the FIFO, one pop frees one slot.
    lat = 1;
    do_reset();
    nreq = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (s_req) begin
        check32("full_addr", s_addr, 32'(4 * nreq));
        nreq++;
      end
    end
    check32("full_nreq",  32'(nreq),  32'd4);
    check32("full_valid", 32'(s_vld), 32'd1);
    check32("full_head",  s_pc,       32'h0);
    id_ready_i = 1'b1;
    tick();
    check32("pop_req",  32'(s_req), 32'd1);
    check32("pop_addr", s_addr,     32'h10);
    id_ready_i = 1'b0;
    tick();
    check32("pop_noreq", 32'(s_req), 32'd0);
    check32("pop_head",  s_pc,       32'h4);
    tick();
    check32("pop_noreq2", 32'(s_req), 32'd0);

    // 3-cycle memory, redirect while a request is outstanding.
    lat = 3;
    do_reset();
    repeat (7) tick();
    check32("r3_req",   32'(s_req), 32'd1);
    check32("r3_addr",  s_addr,     32'h8);
    check32("r3_valid", 32'(s_vld), 32'd1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    tick();
    check32("r3_redir_noreq", 32'(s_req), 32'd0);
    redirect_i = 1'b0;
    tick();
    check32("r3_flush_valid", 32'(s_vld), 32'd0);
    check32("r3_discard_req", 32'(s_req), 32'd0);
    tick();
    check32("r3_stale_valid", 32'(s_vld), 32'd0);
    check32("r3_stale_req",   32'(s_req), 32'd0);
    tick();
    check32("r3_tgt_req",  32'(s_req), 32'd1);
    check32("r3_tgt_addr", s_addr,     32'h100);
    id_ready_i = 1'b1;
    wait_valid("r3_tgt", 32'h100);

    // Redirect coinciding with rvalid and a pop.
    lat = 1;
    do_reset();
    id_ready_i = 1'b1;
    tick();
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    tick();
    check32("rp_noreq", 32'(s_req), 32'd0);
    check32("rp_valid", 32'(s_vld), 32'd1);
    redirect_i = 1'b0;
    tick();
    check32("rp_empty", 32'(s_vld), 32'd0);
    check32("rp_req",   32'(s_req), 32'd1);
    check32("rp_addr",  s_addr,     32'h200);
    tick();
    check32("rp_empty2", 32'(s_vld), 32'd0);
    tick();
    check32("rp_valid2", 32'(s_vld), 32'd1);
    check32("rp_pc",     s_pc,       32'h200);

    // Unaligned target, then wrap at the top of the address space.
    lat = 1;
    do_reset();
    id_ready_i    = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    tick();
    check32("al_noreq", 32'(s_req), 32'd0);
    redirect_i = 1'b0;
    tick();
    check32("al_req",  32'(s_req), 32'd1);
    check32("al_addr", s_addr,     32'h100);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    check32("wr_noreq", 32'(s_req), 32'd0);
    redirect_i = 1'b0;
    tick();
    check32("wr_addr0", s_addr,     32'hFFFF_FFFC);
    check32("wr_req0",  32'(s_req), 32'd1);
    tick();
    check32("wr_addr1", s_addr,     32'h0);
    check32("wr_req1",  32'(s_req), 32'd1);
    tick();
    check32("wr_pc0",    s_pc,    32'hFFFF_FFFC);
    check32("wr_instr0", s_instr, 32'hFFFF_FFFC);
    tick();
    check32("wr_pc1", s_pc, 32'h0);

    // Reset while waiting; the late response lands in IDLE and is ignored.
    lat = 3;
    do_reset();
    id_ready_i = 1'b1;
    tick();
    check32("lr_req0", 32'(s_req), 32'd1);
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    check32("lr_late_rvalid", 32'(imem_rvalid_i), 32'd1);
    check32("lr_req",         32'(s_req),         32'd1);
    check32("lr_addr",        s_addr,             32'h0);
    check32("lr_valid",       32'(s_vld),         32'd0);
    tick();
    check32("lr_valid2", 32'(s_vld), 32'd0);
    wait_valid("lr_tgt", 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
